// File: rtl/idu_queue_if.sv
// idu_queue handshake bundle: fetch-side push, consumer-side pop, flush, count.
// master drives requests; slave is the queue itself.
interface idu_queue_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_instr_i;
  logic [PC_W-1:0] in_pc_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [PC_W-1:0] out_pc_o;
  logic [3:0]      out_op_o;
  logic [2:0]      out_funct3_o;
  logic            out_alt_o;
  logic [31:0]     out_imm_o;
  logic [4:0]      out_rs1_o;
  logic [4:0]      out_rs2_o;
  logic [4:0]      out_rd_o;
  logic [CW-1:0]   count_o;

  modport master (
    output in_valid_i, in_instr_i, in_pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_op_o, out_funct3_o,
    input  out_alt_o, out_imm_o, out_rs1_o, out_rs2_o, out_rd_o, count_o
  );

  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_op_o, out_funct3_o,
    output out_alt_o, out_imm_o, out_rs1_o, out_rs2_o, out_rd_o, count_o
  );
endinterface

// File: rtl/idu_queue.sv
// RV32I decode stage with a DEPTH-entry queue of decoded records.
// Define IDU_QUEUE_RV32M_EN to decode MUL/DIV (op 10); otherwise ILLEGAL.
module idu_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input logic       clk_in,
  input logic       rst_in,
  idu_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_ILL  = 4'd0;
  localparam logic [3:0] OP_LUI  = 4'd1;
  localparam logic [3:0] OP_AUI  = 4'd2;
  localparam logic [3:0] OP_JAL  = 4'd3;
  localparam logic [3:0] OP_JALR = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_ALUI = 4'd8;
  localparam logic [3:0] OP_ALUR = 4'd9;
  localparam logic [3:0] OP_MD   = 4'd10;
  localparam logic [3:0] OP_FNC  = 4'd11;
  localparam logic [3:0] OP_SYS  = 4'd12;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      op;
    logic [2:0]      funct3;
    logic            alt;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } rec_t;

  logic [31:0] w;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  rec_t        dec;

  assign w     = q.in_instr_i;
  assign opc   = w[6:0];
  assign f3    = w[14:12];
  assign f7    = w[31:25];
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'b0};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.pc     = q.in_pc_i;
    dec.funct3 = f3;
    dec.rs1    = w[19:15];
    dec.rs2    = w[24:20];
    dec.rd     = w[11:7];
    unique case (opc)
      7'b0110111: begin dec.op = OP_LUI; dec.imm = imm_u; end
      7'b0010111: begin dec.op = OP_AUI; dec.imm = imm_u; end
      7'b1101111: begin dec.op = OP_JAL; dec.imm = imm_j; end
      7'b1100111:
        if (f3 == 3'b000) begin
          dec.op  = OP_JALR;
          dec.imm = imm_i;
        end
      7'b1100011:
        if (f3 != 3'b010 && f3 != 3'b011) begin
          dec.op  = OP_BR;
          dec.imm = imm_b;
        end
      7'b0000011:
        if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
          dec.op  = OP_LD;
          dec.imm = imm_i;
        end
      7'b0100011:
        if (f3 <= 3'b010) begin
          dec.op  = OP_ST;
          dec.imm = imm_s;
        end
      7'b0010011:
        // shift-immediates carry funct7 in the immediate field
        if ((f3 == 3'b001 && f7 == 7'b0000000) ||
            (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
            (f3 != 3'b001 && f3 != 3'b101)) begin
          dec.op  = OP_ALUI;
          dec.imm = imm_i;
          dec.alt = (f3 == 3'b101) & w[30];
        end
      7'b0110011:
        if (f7 == 7'b0000000 ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.op  = OP_ALUR;
          dec.alt = w[30];
        end
`ifdef IDU_QUEUE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          dec.op = OP_MD;
        end
`endif
      7'b0001111: begin dec.op = OP_FNC; dec.imm = imm_i; end
      7'b1110011: begin dec.op = OP_SYS; dec.imm = imm_i; end
      default: dec.op = OP_ILL;
    endcase
  end

  rec_t          mem [DEPTH];
  rec_t          last;
  rec_t          head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          push, pop;

  assign q.in_ready_o  = (cnt != CW'(DEPTH));
  assign q.out_valid_o = (cnt != '0);
  assign push = q.in_valid_i & q.in_ready_o;
  assign pop  = q.out_valid_o & q.out_ready_i;

  always_ff @(posedge clk_in) begin
    if (push && !q.flush_i && !rst_in) mem[wptr] <= dec;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      last <= '0;
    end else if (q.flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        last <= mem[rptr];
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // an empty queue keeps showing the record it last handed out
  assign head = q.out_valid_o ? mem[rptr] : last;

  assign q.out_pc_o     = head.pc;
  assign q.out_op_o     = head.op;
  assign q.out_funct3_o = head.funct3;
  assign q.out_alt_o    = head.alt;
  assign q.out_imm_o    = head.imm;
  assign q.out_rs1_o    = head.rs1;
  assign q.out_rs2_o    = head.rs2;
  assign q.out_rd_o     = head.rd;
  assign q.count_o      = cnt;
endmodule

// File: tb/tb_idu_queue.sv
// Randomized scoreboard bench for idu_queue with directed decode cases.
// Monitor pops expected records on output handshakes at the falling edge.
module tb_idu_queue;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IDU_QUEUE_RV32M_EN
  localparam bit RV32M = 1'b1;
`else
  localparam bit RV32M = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idu_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();
  idu_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .q     (bus)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t last_exp = '0;
  int   mon_cnt = 0;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic exp_t model(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    int opc, f3, f7, op;
    byte fmt;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    op  = 0;
    fmt = "N";
    case (opc)
      'h37: begin op = 1; fmt = "U"; end
      'h17: begin op = 2; fmt = "U"; end
      'h6F: begin op = 3; fmt = "J"; end
      'h67: if (f3 == 0) begin op = 4; fmt = "I"; end
      'h63: if (f3 != 2 && f3 != 3) begin op = 5; fmt = "B"; end
      'h03: if (f3 inside {0, 1, 2, 4, 5}) begin op = 6; fmt = "I"; end
      'h23: if (f3 < 3) begin op = 7; fmt = "S"; end
      'h13: begin
        if (f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 32) : 1'b1) begin
          op = 8; fmt = "I";
        end
      end
      'h33: begin
        if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) op = 9;
        else if (f7 == 1 && RV32M) op = 10;
      end
      'h0F: begin op = 11; fmt = "I"; end
      'h73: begin op = 12; fmt = "I"; end
      default: op = 0;
    endcase
    e.pc  = pc;
    e.op  = 4'(op);
    e.f3  = 3'(f3);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.alt = ((op == 9 || (op == 8 && f3 == 5)) && f7 == 32);
    i12 = w[31:20];
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    case (fmt)
      "I": e.imm = 32'(i12);
      "S": e.imm = 32'($signed({w[31:25], w[11:7]}));
      "B": e.imm = 32'(b13);
      "U": e.imm = w & 32'hFFFF_F000;
      "J": e.imm = 32'(j21);
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  function automatic exp_t dut_head();
    exp_t h;
    h.pc  = bus.out_pc_o;
    h.op  = bus.out_op_o;
    h.f3  = bus.out_funct3_o;
    h.alt = bus.out_alt_o;
    h.imm = bus.out_imm_o;
    h.rs1 = bus.out_rs1_o;
    h.rs2 = bus.out_rs2_o;
    h.rd  = bus.out_rd_o;
    return h;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0] opcs [12];
    logic [6:0] f7;
    int k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
             7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    if ($urandom_range(7) == 0) return $urandom;
    k = $urandom_range(3);
    f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : 7'($urandom);
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom),
            5'($urandom), opcs[$urandom_range(11)]};
  endfunction

  task automatic drive(bit v, logic [31:0] w, logic [31:0] pc,
                       bit rdy, bit fl, bit r);
    @(posedge clk);
    #1;
    rst             = r;
    bus.in_valid_i  = v;
    bus.in_instr_i  = w;
    bus.in_pc_i     = pc;
    bus.out_ready_i = rdy;
    bus.flush_i     = fl;
    if (r || fl) sb.delete();
    else if (v && bus.in_ready_o) sb.push_back(model(w, pc));
  endtask

  always @(negedge clk) begin
    bit acc, pop;
    chk("count", 128'(bus.count_o), 128'(mon_cnt));
    chk("in_ready", 128'(bus.in_ready_o), 128'(mon_cnt != DEPTH));
    chk("out_valid", 128'(bus.out_valid_o), 128'(mon_cnt != 0));
    if (!rst && !bus.flush_i) begin
      if (bus.out_valid_o) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 128'(0), 128'(1));
        end else begin
          chk("head", 128'(dut_head()), 128'(sb[0]));
          if (bus.out_ready_i) last_exp = sb.pop_front();
        end
      end else begin
        chk("hold", 128'(dut_head()), 128'(last_exp));
      end
    end
    acc = bus.in_valid_i && (mon_cnt != DEPTH);
    pop = bus.out_ready_i && (mon_cnt != 0);
    if (rst) begin
      mon_cnt  = 0;
      last_exp = '0;
    end else if (bus.flush_i) begin
      mon_cnt = 0;
    end else begin
      mon_cnt = mon_cnt + int'(acc) - int'(pop);
    end
  end

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = '0;
    bus.in_pc_i     = '0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_ready", 128'(bus.in_ready_o), 128'(1));
    chk("rst_op", 128'(bus.out_op_o), 128'(0));
    chk("rst_imm", 128'(bus.out_imm_o), 128'(0));

    // addi x1,x0,5
    drive(1, 32'h0050_0093, 32'h100, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("addi_valid", 128'(bus.out_valid_o), 128'(1));
    chk("addi_op", 128'(bus.out_op_o), 128'(8));
    chk("addi_imm", 128'(bus.out_imm_o), 128'(5));
    chk("addi_rd", 128'(bus.out_rd_o), 128'(1));
    chk("addi_rs1", 128'(bus.out_rs1_o), 128'(0));
    chk("addi_pc", 128'(bus.out_pc_o), 128'(32'h100));
    drive(0, 0, 0, 1, 0, 0);

    // beq x0,x0,-4
    drive(1, 32'hFE00_0EE3, 32'h200, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("beq_op", 128'(bus.out_op_o), 128'(5));
    chk("beq_f3", 128'(bus.out_funct3_o), 128'(0));
    chk("beq_imm", 128'(bus.out_imm_o), 128'(32'hFFFF_FFFC));
    drive(0, 0, 0, 1, 0, 0);

    // mul, then an unlisted opcode
    drive(1, 32'h0220_8033, 32'h300, 0, 0, 0);
    drive(1, 32'h0000_007F, 32'h304, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mul_op", 128'(bus.out_op_o), 128'(RV32M ? 10 : 0));
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ill_op", 128'(bus.out_op_o), 128'(0));
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // fill to full, third offer must stall
    drive(1, 32'h0010_0113, 32'h400, 0, 0, 0);
    drive(1, 32'h0020_0193, 32'h404, 0, 0, 0);
    drive(1, 32'h0030_0213, 32'h408, 0, 0, 0);
    @(negedge clk);
    chk("full_ready", 128'(bus.in_ready_o), 128'(0));
    chk("full_count", 128'(bus.count_o), 128'(2));
    drive(1, 32'h0030_0213, 32'h408, 1, 0, 0);
    @(negedge clk);
    chk("full_pop_ready", 128'(bus.in_ready_o), 128'(0));
    drive(1, 32'h0030_0213, 32'h408, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0);

    // flush with two held and one offered
    drive(1, 32'h0050_0293, 32'h500, 0, 0, 0);
    drive(1, 32'h0060_0313, 32'h504, 0, 0, 0);
    drive(1, 32'h0070_0393, 32'h508, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("flush_count", 128'(bus.count_o), 128'(0));
    chk("flush_valid", 128'(bus.out_valid_o), 128'(0));
    repeat (2) drive(0, 0, 0, 1, 0, 0);

    // streaming push/pop
    for (int i = 0; i < 16; i++) begin
      drive(1, rand_word(), 32'h600 + 32'(4 * i), 1, 0, 0);
      if (i > 0) begin
        @(negedge clk);
        chk("stream_count", 128'(bus.count_o), 128'(1));
      end
    end
    repeat (2) drive(0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, rand_word(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(2) != 0, $urandom_range(49) == 0,
            $urandom_range(299) == 0);
    end
    repeat (DEPTH + 2) drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("drain_sb", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/idu_queue.md
IDU_QUEUE -- requirements
Module: idu_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of decoded-entry slots; power of two, minimum 2.
REQ-002 Parameter PC_W, default 32, width of the carried instruction address.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 in_valid_i  input  1  fetch offers an instruction.
REQ-006 in_ready_o  output  1  queue accepts; transfer when in_valid_i and in_ready_o are both high.
REQ-007 in_instr_i  input  32  raw instruction word.
REQ-008 in_pc_i  input  PC_W  address of in_instr_i.
REQ-009 flush_i  input  1  discard all held and offered entries.
REQ-010 out_valid_o  output  1  head entry valid.
REQ-011 out_ready_i  input  1  consumer takes head; pop when out_valid_o and out_ready_i are both high.
REQ-012 out_pc_o  output  PC_W  head address.
REQ-013 out_op_o  output  4  head op class: 0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 ALU_IMM, 9 ALU_REG, 10 MULDIV, 11 FENCE, 12 SYSTEM.
REQ-014 out_funct3_o  output  3  head instr[14:12].
REQ-015 out_alt_o  output  1  head instr[30] for SUB/SRA/SRAI, else 0.
REQ-016 out_imm_o  output  32  head sign-extended immediate.
REQ-017 out_rs1_o, out_rs2_o, out_rd_o  output  5 each  head register fields.
REQ-018 count_o  output  $clog2(DEPTH)+1  held entry count.

Function
REQ-019 Decode SHALL be combinational on in_instr_i; the decoded record SHALL be written into the queue on accept.
REQ-020 Accept-to-out_valid_o latency SHALL be exactly 1 cycle when the queue is empty; no same-cycle bypass.
REQ-021 Immediates: I-type instr[31:20]; S-type {instr[31:25],instr[11:7]}; B-type {instr[31],instr[7],instr[30:25],instr[11:8],0}; U-type {instr[31:12],12'b0}; J-type {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended; 0 for ALU_REG, MULDIV, ILLEGAL.
REQ-022 ILLEGAL SHALL result from an unlisted opcode, JALR funct3!=0, branch funct3 010/011, load funct3 011/110/111, store funct3>010, shift-immediate with funct7 other than 0000000/0100000 (0100000 only for funct3 101), or ALU_REG with funct7 other than 0000000/0100000 (0100000 only for funct3 000/101).
REQ-023 in_ready_o SHALL equal (count_o != DEPTH); a pop in the same cycle SHALL NOT raise in_ready_o when full.
REQ-024 Simultaneous push and pop with 0 < count_o < DEPTH SHALL leave count_o unchanged and preserve order.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 When empty: out_valid_o=0, other head outputs hold last popped values.
REQ-027 flush_i SHALL set count_o=0 and pointers to 0 on the next edge; an accept or pop in the flush cycle SHALL be discarded; flush_i overrides all other events.
REQ-028 Output fields SHALL be stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-029 On rst_in high at an edge: count_o=0, pointers=0, out_valid_o=0, out_op_o=0, out_pc_o/out_imm_o/out_funct3_o/out_alt_o/register fields=0.
REQ-030 Reset mid-operation SHALL discard all entries; in_ready_o=1 on the first cycle after reset deasserts.

Configuration
REQ-031 Macro IDU_QUEUE_RV32M_EN defined: opcode 0110011 with funct7 0000001 SHALL decode as MULDIV, all funct3 legal.
REQ-032 Macro IDU_QUEUE_RV32M_EN undefined: that encoding SHALL decode as ILLEGAL; op value 10 never produced.

Verification
REQ-033 Push 0x00500093 (addi x1,x0,5) pc 0x100 -> next cycle out_valid_o=1, op 8, imm 5, rd 1, rs1 0, pc 0x100.
REQ-034 Push 0xFE000EE3 (beq x0,x0,-4) -> op 5, funct3 0, imm 0xFFFFFFFC.
REQ-035 DEPTH=2, out_ready_i=0, push 3 words -> in_ready_o=0 after two accepts; third held; pop releases in order.
REQ-036 Push 0x02208033 (mul) -> op 10 with IDU_QUEUE_RV32M_EN, op 0 without; push 0x0000007F -> op 0.
REQ-037 Two entries held, assert flush_i with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, offered word dropped.
REQ-038 Continuous push/pop of 16 words with out_ready_i=1 -> one output per cycle after first, order preserved, count_o constant 1.
